// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter that owns the register file's single write port.
// Round-robin shares the port between NREQ requesters and runs a one-register-per-cycle clear sequence.
module regfile_wb_arbiter #(
  parameter int NREQ  = 3,
  parameter int AW    = 3,
  parameter int DW    = 8,
  parameter int NREGS = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NREQ-1:0]    REQ_VALID,
  input  logic [NREQ*AW-1:0] REQ_ADDR,
  input  logic [NREQ*DW-1:0] REQ_DATA,
  output logic [NREQ-1:0]    REQ_READY,
  input  logic               CLEAR_REQ,
  output logic               CLEAR_BUSY,
  output logic               WR_EN,
  output logic [AW-1:0]      WR_ADDR,
  output logic [DW-1:0]      WR_DATA,
  output logic [1:0]         GRANT_ID
);

  localparam int CW = AW + 1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      ptr_q, ptr_d;
  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [DW-1:0]   wr_data_q, wr_data_d;
  logic [1:0]      grant_id_q, grant_id_d;
  logic            busy_q, busy_d;

  logic            arb_hit;
  logic [1:0]      arb_idx;
  logic [NREQ-1:0] arb_gnt;
  logic [AW-1:0]   arb_addr;
  logic [DW-1:0]   arb_data;
  logic            clear_last;
  logic            arb_en;
  logic            xfer;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ptr_q      <= 2'(NREQ - 1);
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
    end
  end

  // Search starts just after the last granted requester and wraps around.
  always_comb begin
    arb_hit  = 1'b0;
    arb_idx  = '0;
    arb_gnt  = '0;
    arb_addr = '0;
    arb_data = '0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!arb_hit && REQ_VALID[i] && (i == (int'(ptr_q) + k) % NREQ)) begin
          arb_hit    = 1'b1;
          arb_idx    = 2'(i);
          arb_gnt[i] = 1'b1;
          arb_addr   = REQ_ADDR[i*AW +: AW];
          arb_data   = REQ_DATA[i*DW +: DW];
        end
      end
    end
  end

  // The final clear cycle also arbitrates so a waiting request is taken on the exit edge.
  assign clear_last = (state_q == CLEAR) && (cnt_q == CW'(NREGS));
  assign arb_en     = !RESET && (((state_q == IDLE) && !CLEAR_REQ) || clear_last);
  assign xfer       = arb_en && arb_hit;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    grant_id_d = grant_id_q;
    busy_d     = busy_q;
    case (state_q)
      IDLE: begin
        if (CLEAR_REQ) begin
          state_d   = CLEAR;
          wr_en_d   = 1'b1;
          wr_addr_d = '0;
          wr_data_d = '0;
          busy_d    = 1'b1;
          cnt_d     = CW'(1);
        end
      end
      CLEAR: begin
        if (!clear_last) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q[AW-1:0];
          wr_data_d = '0;
          cnt_d     = cnt_q + CW'(1);
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (xfer) begin
      wr_en_d    = 1'b1;
      wr_addr_d  = arb_addr;
      wr_data_d  = arb_data;
      grant_id_d = arb_idx;
      ptr_d      = arb_idx;
    end
  end

  always_comb begin
    REQ_READY  = arb_en ? arb_gnt : '0;
    WR_EN      = wr_en_q;
    WR_ADDR    = wr_addr_q;
    WR_DATA    = wr_data_q;
    GRANT_ID   = grant_id_q;
    CLEAR_BUSY = busy_q;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic against a cycle-level reference model.
// A small register file driven by the DUT's write port is compared with the model's register contents.
module tb_regfile_wb_arbiter;
  localparam int NREQ  = 3;
  localparam int AW    = 3;
  localparam int DW    = 8;
  localparam int NREGS = 8;

  logic               CLK;
  logic               RESET;
  logic [NREQ-1:0]    REQ_VALID;
  logic [NREQ*AW-1:0] REQ_ADDR;
  logic [NREQ*DW-1:0] REQ_DATA;
  logic [NREQ-1:0]    REQ_READY;
  logic               CLEAR_REQ;
  logic               CLEAR_BUSY;
  logic               WR_EN;
  logic [AW-1:0]      WR_ADDR;
  logic [DW-1:0]      WR_DATA;
  logic [1:0]         GRANT_ID;

  regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .NREGS(NREGS)) dut (
    .CLK(CLK), .RESET(RESET), .REQ_VALID(REQ_VALID), .REQ_ADDR(REQ_ADDR),
    .REQ_DATA(REQ_DATA), .REQ_READY(REQ_READY), .CLEAR_REQ(CLEAR_REQ),
    .CLEAR_BUSY(CLEAR_BUSY), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR),
    .WR_DATA(WR_DATA), .GRANT_ID(GRANT_ID)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_compared = 0;
  int n_mismatched = 0;

  logic [NREQ-1:0] s_valid;
  logic [AW-1:0]   s_addr [NREQ];
  logic [DW-1:0]   s_data [NREQ];
  logic            s_clr, s_rst;
  int              stim_mode;

  logic            m_wr_en, m_busy;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_data;
  int              m_gid, m_ptr, m_clr;
  logic [NREQ-1:0] exp_ready;
  logic [DW-1:0]   mrf [NREGS];
  logic [DW-1:0]   rf  [NREGS];

  // Register file as the DUT's write port would update it.
  always @(posedge CLK) if (WR_EN) rf[WR_ADDR] <= WR_DATA;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [NREQ-1:0] model_grant(input logic [NREQ-1:0] v, input int p);
    logic [NREQ-1:0] g;
    g = '0;
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (p + k) % NREQ;
      if (v[i]) begin
        g[i] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  function automatic int onehot_index(input logic [NREQ-1:0] g);
    for (int i = 0; i < NREQ; i++) if (g[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_wr_en = 1'b0; m_addr = '0; m_data = '0; m_gid = 0;
    m_busy = 1'b0; m_ptr = NREQ - 1; m_clr = -1;
  endtask

  // One clock cycle: drive, check outputs mid-cycle, then advance the model across the edge.
  task automatic applyStimulus();
    bit was_idle;
    @(negedge CLK);
    RESET = s_rst;
    CLEAR_REQ = s_clr;
    REQ_VALID = s_valid;
    for (int i = 0; i < NREQ; i++) begin
      REQ_ADDR[i*AW +: AW] = s_addr[i];
      REQ_DATA[i*DW +: DW] = s_data[i];
    end
    #1;
    if (s_rst) exp_ready = '0;
    else if (m_clr < 0) exp_ready = s_clr ? '0 : model_grant(s_valid, m_ptr);
    else if (m_clr == NREGS) exp_ready = model_grant(s_valid, m_ptr);
    else exp_ready = '0;
    checkOutput("req_ready", 32'(REQ_READY), 32'(exp_ready));
    checkOutput("wr_en", 32'(WR_EN), 32'(m_wr_en));
    checkOutput("wr_addr", 32'(WR_ADDR), 32'(m_addr));
    checkOutput("wr_data", 32'(WR_DATA), 32'(m_data));
    checkOutput("grant_id", 32'(GRANT_ID), 32'(m_gid));
    checkOutput("clear_busy", 32'(CLEAR_BUSY), 32'(m_busy));
    @(posedge CLK);
    if (m_wr_en) mrf[m_addr] = m_data;
    was_idle = (m_clr < 0);
    if (s_rst) begin
      model_reset();
    end else if (m_clr >= 0 && m_clr < NREGS) begin
      m_wr_en = 1'b1; m_addr = AW'(m_clr); m_data = '0; m_clr++;
    end else begin
      if (m_clr == NREGS) begin
        m_clr = -1; m_busy = 1'b0;
      end
      if (was_idle && s_clr) begin
        m_clr = 1; m_wr_en = 1'b1; m_addr = '0; m_data = '0; m_busy = 1'b1;
      end else if (exp_ready != '0) begin
        m_ptr = onehot_index(exp_ready);
        m_wr_en = 1'b1; m_addr = s_addr[m_ptr]; m_data = s_data[m_ptr]; m_gid = m_ptr;
      end else begin
        m_wr_en = 1'b0;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (stim_mode == 0 && exp_ready[i]) s_valid[i] = 1'b0;
      if (stim_mode == 2 && (!s_valid[i] || exp_ready[i])) begin
        s_valid[i] = 1'($urandom_range(0, 1));
        s_addr[i]  = AW'($urandom);
        s_data[i]  = DW'($urandom);
      end
    end
    if (stim_mode == 2) begin
      s_clr = ($urandom_range(0, 15) == 0);
      s_rst = ($urandom_range(0, 63) == 0);
    end
  endtask

  task automatic doReset();
    s_rst = 1'b1; s_clr = 1'b0; s_valid = '0;
    applyStimulus();
    applyStimulus();
    s_rst = 1'b0;
  endtask

  task automatic loadRegs();
    stim_mode = 0;
    for (int r = 0; r < NREGS; r++) begin
      s_valid = 3'b001; s_addr[0] = AW'(r); s_data[0] = DW'(8'h40 + r);
      applyStimulus();
    end
    applyStimulus();
    applyStimulus();
  endtask

  initial begin
    for (int r = 0; r < NREGS; r++) begin
      rf[r] = '0;
      mrf[r] = '0;
    end
    for (int i = 0; i < NREQ; i++) begin
      s_addr[i] = '0;
      s_data[i] = '0;
    end
    RESET = 1'b1; CLEAR_REQ = 1'b0; REQ_VALID = '0; REQ_ADDR = '0; REQ_DATA = '0;
    s_valid = '0; s_clr = 1'b0; s_rst = 1'b1; stim_mode = 0;
    model_reset();
    @(posedge CLK);

    // Single write from requester 0 lands in R5.
    doReset();
    s_valid = 3'b001; s_addr[0] = 3'd5; s_data[0] = 8'h3C;
    applyStimulus();
    applyStimulus();
    applyStimulus();
    #1 checkOutput("r5_after_write", 32'(rf[5]), 32'h3C);

    // All requesters valid continuously: strict rotation.
    stim_mode = 1;
    s_valid = 3'b111;
    for (int i = 0; i < NREQ; i++) begin
      s_addr[i] = AW'(i + 1);
      s_data[i] = DW'(8'hA0 + i);
    end
    repeat (7) applyStimulus();

    // Same destination from requesters 0 and 2: later grant wins.
    stim_mode = 0;
    doReset();
    s_valid = 3'b101; s_addr[0] = 3'd4; s_data[0] = 8'h11; s_addr[2] = 3'd4; s_data[2] = 8'h22;
    repeat (4) applyStimulus();
    #1 checkOutput("r4_last_grant", 32'(rf[4]), 32'h22);

    // Clear with requester 1 waiting; it is taken on the exit edge.
    loadRegs();
    s_valid = 3'b010; s_addr[1] = 3'd6; s_data[1] = 8'h99; s_clr = 1'b1;
    applyStimulus();
    s_clr = 1'b0;
    repeat (10) applyStimulus();
    #1;
    for (int r = 0; r < NREGS; r++)
      checkOutput($sformatf("r%0d_after_clear", r), 32'(rf[r]), (r == 6) ? 32'h99 : 32'h0);

    // Reset while WR_ADDR=2 of the clear is on the port.
    loadRegs();
    s_clr = 1'b1;
    applyStimulus();
    s_clr = 1'b0;
    applyStimulus();
    applyStimulus();
    s_rst = 1'b1;
    applyStimulus();
    s_rst = 1'b0;
    #1;
    for (int r = 3; r < NREGS; r++)
      checkOutput($sformatf("r%0d_kept", r), 32'(rf[r]), 32'(8'h40 + r));
    s_valid = 3'b011; s_addr[0] = 3'd3; s_data[0] = 8'h5A; s_addr[1] = 3'd7; s_data[1] = 8'h6B;
    repeat (4) applyStimulus();

    // Clear and all requests rise together: clear goes first.
    s_valid = 3'b111; s_clr = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      s_addr[i] = AW'(i);
      s_data[i] = DW'(8'hC0 + i);
    end
    applyStimulus();
    s_clr = 1'b0;
    repeat (13) applyStimulus();

    // Random traffic with occasional clears and resets.
    stim_mode = 2;
    repeat (3000) applyStimulus();
    stim_mode = 0;
    s_valid = '0; s_clr = 1'b0; s_rst = 1'b0;
    repeat (12) applyStimulus();
    #1;
    for (int r = 0; r < NREGS; r++)
      checkOutput($sformatf("final_r%0d", r), 32'(rf[r]), 32'(mrf[r]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
